// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS control FSM and the ALU control decoder.
// Covers state codes, OpCode/Funct values, ALUOp codes and the ID dispatch table.
package mips_ctrl_pkg;

  localparam int ALUOP_W = 4;

  typedef enum logic [3:0] {
    S_IF   = 4'd0,
    S_ID   = 4'd1,
    S_EXR  = 4'd2,
    S_WBR  = 4'd3,
    S_EXI  = 4'd4,
    S_WBI  = 4'd5,
    S_ADDR = 4'd6,
    S_MRD  = 4'd7,
    S_WBM  = 4'd8,
    S_MWR  = 4'd9,
    S_BR   = 4'd10,
    S_J    = 4'd11,
    S_JR   = 4'd12
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_SPEC2 = 6'h1c;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTI  = 6'h0a;
  localparam logic [5:0] OP_SLTIU = 6'h0b;
  localparam logic [5:0] OP_ANDI  = 6'h0c;
  localparam logic [5:0] OP_ORI   = 6'h0d;
  localparam logic [5:0] OP_LUI   = 6'h0f;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2b;

  localparam logic [5:0] FN_SLL  = 6'h00;
  localparam logic [5:0] FN_SRL  = 6'h02;
  localparam logic [5:0] FN_SRA  = 6'h03;
  localparam logic [5:0] FN_JR   = 6'h08;
  localparam logic [5:0] FN_JALR = 6'h09;
  localparam logic [5:0] FN_MUL  = 6'h02;

  localparam logic [ALUOP_W-1:0] ALU_ADD   = 4'b0000;
  localparam logic [ALUOP_W-1:0] ALU_SUB   = 4'b0001;
  localparam logic [ALUOP_W-1:0] ALU_MUL   = 4'b0010;
  localparam logic [ALUOP_W-1:0] ALU_AND   = 4'b0100;
  localparam logic [ALUOP_W-1:0] ALU_OR    = 4'b0101;
  localparam logic [ALUOP_W-1:0] ALU_SLT   = 4'b0110;
  localparam logic [ALUOP_W-1:0] ALU_FUNCT = 4'b0111;
  localparam logic [ALUOP_W-1:0] ALU_ADDU  = 4'b1000;
  localparam logic [ALUOP_W-1:0] ALU_SLTU  = 4'b1110;

  // S_IF doubles as "unsupported": the FSM flags Illegal when ID dispatches there.
  function automatic state_t decode_target(input logic [5:0] op, input logic [5:0] fn);
    state_t t;
    t = S_IF;
    case (op)
      OP_RTYPE: t = (fn == FN_JR || fn == FN_JALR) ? S_JR : S_EXR;
      OP_SPEC2: t = (fn == FN_MUL) ? S_EXR : S_IF;
      OP_LW, OP_SW: t = S_ADDR;
      OP_BEQ, OP_BNE: t = S_BR;
      OP_J, OP_JAL: t = S_J;
      OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU,
      OP_ANDI, OP_ORI, OP_LUI: t = S_EXI;
      default: t = S_IF;
    endcase
    return t;
  endfunction

endpackage

// File: rtl/aluop_encoder.sv
// Combinational ALU operand/operation selection for the multi-cycle control FSM.
// Produces ALUOp, ALUSrcA, ExtOp and LuiOp from the current state and instruction fields.
module aluop_encoder
  import mips_ctrl_pkg::*;
(
  input  state_t             state,
  input  logic [5:0]         op,
  input  logic [5:0]         fn,
  output logic [ALUOP_W-1:0] alu_op,
  output logic [1:0]         alu_src_a,
  output logic               ext_op,
  output logic               lui_op
);

  always_comb begin
    alu_op    = ALU_ADD;
    alu_src_a = 2'd0;
    ext_op    = 1'b0;
    lui_op    = 1'b0;
    case (state)
      S_ID: ext_op = 1'b1;
      S_EXR: begin
        // mul shares funct 0x02 with srl, so shamt is only selected for real R-type shifts
        if (op == OP_RTYPE && (fn == FN_SLL || fn == FN_SRL || fn == FN_SRA))
          alu_src_a = 2'd2;
        else
          alu_src_a = 2'd1;
        alu_op = (op == OP_SPEC2) ? ALU_MUL : ALU_FUNCT;
      end
      S_EXI: begin
        alu_src_a = 2'd1;
        ext_op    = !(op == OP_ANDI || op == OP_ORI);
        case (op)
          OP_ADDIU: alu_op = ALU_ADDU;
          OP_ANDI:  alu_op = ALU_AND;
          OP_ORI:   alu_op = ALU_OR;
          OP_SLTI:  alu_op = ALU_SLT;
          OP_SLTIU: alu_op = ALU_SLTU;
          OP_LUI: begin
            alu_src_a = 2'd3;
            lui_op    = 1'b1;
            alu_op    = ALU_OR;
          end
          default:  alu_op = ALU_ADD;
        endcase
      end
      S_ADDR: begin
        alu_src_a = 2'd1;
        ext_op    = 1'b1;
      end
      S_BR: begin
        alu_src_a = 2'd1;
        alu_op    = ALU_SUB;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/multi_cycle_control.sv
// Main control FSM for the multi-cycle MIPS datapath.
// Moore outputs from state plus IR fields; MemReady only gates the fetch write enables and memory waits.
module multi_cycle_control
  import mips_ctrl_pkg::*;
#(
  parameter state_t RESET_STATE = S_IF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [5:0]         OpCode,
  input  logic [5:0]         Funct,
  input  logic               MemReady,
  output logic               PCWrite,
  output logic               PCWriteCond,
  output logic               BranchNe,
  output logic               IorD,
  output logic               MemRead,
  output logic               MemWrite,
  output logic               IRWrite,
  output logic               RegWrite,
  output logic [1:0]         RegDst,
  output logic [1:0]         MemtoReg,
  output logic [1:0]         ALUSrcA,
  output logic [1:0]         ALUSrcB,
  output logic               ExtOp,
  output logic               LuiOp,
  output logic [ALUOP_W-1:0] ALUOp,
  output logic [1:0]         PCSource,
  output logic               Illegal
);

  state_t             state, state_next, id_target;
  logic [ALUOP_W-1:0] enc_alu_op;
  logic [1:0]         enc_alu_src_a;
  logic               enc_ext_op, enc_lui_op;

  aluop_encoder u_aluop_encoder (
    .state     (state),
    .op        (OpCode),
    .fn        (Funct),
    .alu_op    (enc_alu_op),
    .alu_src_a (enc_alu_src_a),
    .ext_op    (enc_ext_op),
    .lui_op    (enc_lui_op)
  );

  assign id_target = decode_target(OpCode, Funct);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= RESET_STATE;
    else       state <= state_next;
  end

  always_comb begin
    state_next  = S_IF;
    PCWrite     = 1'b0;
    PCWriteCond = 1'b0;
    BranchNe    = 1'b0;
    IorD        = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    IRWrite     = 1'b0;
    RegWrite    = 1'b0;
    RegDst      = 2'd0;
    MemtoReg    = 2'd0;
    ALUSrcB     = 2'd0;
    PCSource    = 2'd0;
    Illegal     = 1'b0;
    ALUOp       = enc_alu_op;
    ALUSrcA     = enc_alu_src_a;
    ExtOp       = enc_ext_op;
    LuiOp       = enc_lui_op;
    case (state)
      S_IF: begin
        MemRead    = 1'b1;
        ALUSrcB    = 2'd1;
        PCWrite    = MemReady;
        IRWrite    = MemReady;
        state_next = MemReady ? S_ID : S_IF;
      end
      S_ID: begin
        ALUSrcB    = 2'd3;
        state_next = id_target;
        Illegal    = (id_target == S_IF);
      end
      S_EXR: state_next = S_WBR;
      S_WBR: begin
        RegWrite = 1'b1;
        RegDst   = 2'd1;
      end
      S_EXI: begin
        ALUSrcB    = 2'd2;
        state_next = S_WBI;
      end
      S_WBI: RegWrite = 1'b1;
      S_ADDR: begin
        ALUSrcB    = 2'd2;
        state_next = (OpCode == OP_SW) ? S_MWR : S_MRD;
      end
      S_MRD: begin
        MemRead    = 1'b1;
        IorD       = 1'b1;
        state_next = MemReady ? S_WBM : S_MRD;
      end
      S_WBM: begin
        RegWrite = 1'b1;
        MemtoReg = 2'd1;
      end
      S_MWR: begin
        MemWrite   = 1'b1;
        IorD       = 1'b1;
        state_next = MemReady ? S_IF : S_MWR;
      end
      S_BR: begin
        PCWriteCond = 1'b1;
        PCSource    = 2'd1;
        BranchNe    = (OpCode == OP_BNE);
      end
      S_J: begin
        PCWrite  = 1'b1;
        PCSource = 2'd2;
        if (OpCode == OP_JAL) begin
          RegWrite = 1'b1;
          RegDst   = 2'd2;
          MemtoReg = 2'd2;
        end
      end
      S_JR: begin
        PCWrite  = 1'b1;
        PCSource = 2'd3;
        if (Funct == FN_JALR) begin
          RegWrite = 1'b1;
          RegDst   = 2'd1;
          MemtoReg = 2'd2;
        end
      end
      default: state_next = S_IF;
    endcase
    // Reset forces every output low combinationally, including mid-access memory requests.
    if (reset) begin
      PCWrite     = 1'b0;
      PCWriteCond = 1'b0;
      BranchNe    = 1'b0;
      IorD        = 1'b0;
      MemRead     = 1'b0;
      MemWrite    = 1'b0;
      IRWrite     = 1'b0;
      RegWrite    = 1'b0;
      RegDst      = 2'd0;
      MemtoReg    = 2'd0;
      ALUSrcA     = 2'd0;
      ALUSrcB     = 2'd0;
      ExtOp       = 1'b0;
      LuiOp       = 1'b0;
      ALUOp       = '0;
      PCSource    = 2'd0;
      Illegal     = 1'b0;
    end
  end

endmodule

// File: tb/tb_multi_cycle_control.sv
// Self-checking bench for multi_cycle_control: instruction-level reference model builds
// per-cycle expected control words (with don't-care masks) for directed and random streams.
module tb_multi_cycle_control;

  logic       clk = 1'b0;
  logic       reset, MemReady;
  logic [5:0] OpCode, Funct;
  logic       PCWrite, PCWriteCond, BranchNe, IorD, MemRead, MemWrite, IRWrite, RegWrite;
  logic [1:0] RegDst, MemtoReg, ALUSrcA, ALUSrcB, PCSource;
  logic       ExtOp, LuiOp, Illegal;
  logic [3:0] ALUOp;

  always #5 clk = ~clk;

  multi_cycle_control dut (
    .clk(clk), .reset(reset), .OpCode(OpCode), .Funct(Funct), .MemReady(MemReady),
    .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .BranchNe(BranchNe), .IorD(IorD),
    .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite), .RegWrite(RegWrite),
    .RegDst(RegDst), .MemtoReg(MemtoReg), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
    .ExtOp(ExtOp), .LuiOp(LuiOp), .ALUOp(ALUOp), .PCSource(PCSource), .Illegal(Illegal)
  );

  typedef struct packed {
    logic       pc_write, pc_write_cond, branch_ne, iord, mem_read, mem_write, ir_write, reg_write;
    logic [1:0] reg_dst, mem_to_reg, alu_src_a, alu_src_b;
    logic       ext_op, lui_op;
    logic [3:0] alu_op;
    logic [1:0] pc_source;
    logic       illegal;
  } ctl_t;

  typedef struct {
    logic ready;
    ctl_t e;
    ctl_t m;
  } step_t;

  typedef enum {C_R, C_SHIFT, C_MUL, C_IMM, C_LUI, C_LW, C_SW, C_BR, C_J, C_JR, C_ILL} cls_t;

  ctl_t  act;
  step_t steps[$];
  int    n_chk = 0;
  int    n_pass = 0;

  assign act = {PCWrite, PCWriteCond, BranchNe, IorD, MemRead, MemWrite, IRWrite, RegWrite,
                RegDst, MemtoReg, ALUSrcA, ALUSrcB, ExtOp, LuiOp, ALUOp, PCSource, Illegal};

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  function automatic cls_t classify(input logic [5:0] opc, input logic [5:0] fnc);
    case (opc)
      6'h00: begin
        if (fnc == 6'h08 || fnc == 6'h09) return C_JR;
        if (fnc == 6'h00 || fnc == 6'h02 || fnc == 6'h03) return C_SHIFT;
        return C_R;
      end
      6'h1c: return (fnc == 6'h02) ? C_MUL : C_ILL;
      6'h23: return C_LW;
      6'h2b: return C_SW;
      6'h04, 6'h05: return C_BR;
      6'h02, 6'h03: return C_J;
      6'h08, 6'h09, 6'h0a, 6'h0b, 6'h0c, 6'h0d: return C_IMM;
      6'h0f: return C_LUI;
      default: return C_ILL;
    endcase
  endfunction

  function automatic logic [3:0] imm_alu_op(input logic [5:0] opc);
    case (opc)
      6'h09: return 4'b1000;
      6'h0c: return 4'b0100;
      6'h0d: return 4'b0101;
      6'h0a: return 4'b0110;
      6'h0b: return 4'b1110;
      default: return 4'b0000;
    endcase
  endfunction

  function automatic ctl_t base_mask();
    ctl_t m = '0;
    m.pc_write = 1; m.pc_write_cond = 1; m.mem_read = 1; m.mem_write = 1;
    m.ir_write = 1; m.reg_write = 1; m.illegal = 1;
    return m;
  endfunction

  task automatic push(input logic r, input ctl_t e, input ctl_t m);
    step_t s;
    s.ready = r; s.e = e; s.m = m;
    steps.push_back(s);
  endtask

  // Expected cycle-by-cycle control words for one instruction, including stall cycles.
  task automatic gen_instr(input logic [5:0] opc, input logic [5:0] fnc, input int if_stall,
                           input int mem_stall);
    ctl_t e, m, bm;
    cls_t c;
    logic r;
    c  = classify(opc, fnc);
    bm = base_mask();
    for (int i = 0; i <= if_stall; i++) begin
      r = (i == if_stall);
      e = '0; m = bm;
      m.iord = 1; m.alu_src_a = '1; m.alu_src_b = '1; m.alu_op = '1; m.pc_source = '1;
      e.mem_read = 1; e.alu_src_b = 2'd1; e.pc_write = r; e.ir_write = r;
      push(r, e, m);
    end
    e = '0; m = bm;
    m.alu_src_a = '1; m.alu_src_b = '1; m.alu_op = '1;
    e.alu_src_b = 2'd3; e.illegal = (c == C_ILL);
    push(1'($urandom_range(0, 1)), e, m);
    case (c)
      C_R, C_SHIFT, C_MUL: begin
        e = '0; m = bm; m.alu_src_a = '1; m.alu_src_b = '1; m.alu_op = '1;
        e.alu_src_a = (c == C_SHIFT) ? 2'd2 : 2'd1;
        e.alu_op    = (c == C_MUL) ? 4'b0010 : 4'b0111;
        push(1'($urandom_range(0, 1)), e, m);
        e = '0; m = bm; m.reg_dst = '1; m.mem_to_reg = '1;
        e.reg_write = 1; e.reg_dst = 2'd1;
        push(1'($urandom_range(0, 1)), e, m);
      end
      C_IMM, C_LUI: begin
        e = '0; m = bm;
        m.alu_src_a = '1; m.alu_src_b = '1; m.alu_op = '1; m.ext_op = 1; m.lui_op = 1;
        e.alu_src_b = 2'd2;
        if (c == C_LUI) begin
          e.alu_src_a = 2'd3; e.lui_op = 1; e.alu_op = 4'b0101; e.ext_op = 1;
        end else begin
          e.alu_src_a = 2'd1; e.alu_op = imm_alu_op(opc);
          e.ext_op = !(opc == 6'h0c || opc == 6'h0d);
        end
        push(1'($urandom_range(0, 1)), e, m);
        e = '0; m = bm; m.reg_dst = '1; m.mem_to_reg = '1;
        e.reg_write = 1;
        push(1'($urandom_range(0, 1)), e, m);
      end
      C_LW, C_SW: begin
        e = '0; m = bm; m.alu_src_a = '1; m.alu_src_b = '1; m.alu_op = '1; m.ext_op = 1;
        e.alu_src_a = 2'd1; e.alu_src_b = 2'd2; e.ext_op = 1;
        push(1'($urandom_range(0, 1)), e, m);
        for (int i = 0; i <= mem_stall; i++) begin
          r = (i == mem_stall);
          e = '0; m = bm; m.iord = 1; e.iord = 1;
          if (c == C_LW) e.mem_read = 1; else e.mem_write = 1;
          push(r, e, m);
        end
        if (c == C_LW) begin
          e = '0; m = bm; m.reg_dst = '1; m.mem_to_reg = '1;
          e.reg_write = 1; e.mem_to_reg = 2'd1;
          push(1'($urandom_range(0, 1)), e, m);
        end
      end
      C_BR: begin
        e = '0; m = bm;
        m.alu_src_a = '1; m.alu_src_b = '1; m.alu_op = '1; m.pc_source = '1; m.branch_ne = 1;
        e.alu_src_a = 2'd1; e.alu_op = 4'b0001; e.pc_write_cond = 1; e.pc_source = 2'd1;
        e.branch_ne = (opc == 6'h05);
        push(1'($urandom_range(0, 1)), e, m);
      end
      C_J, C_JR: begin
        e = '0; m = bm; m.pc_source = '1;
        e.pc_write = 1; e.pc_source = (c == C_J) ? 2'd2 : 2'd3;
        if ((c == C_J && opc == 6'h03) || (c == C_JR && fnc == 6'h09)) begin
          m.reg_dst = '1; m.mem_to_reg = '1;
          e.reg_write = 1; e.mem_to_reg = 2'd2; e.reg_dst = (c == C_J) ? 2'd2 : 2'd1;
        end
        push(1'($urandom_range(0, 1)), e, m);
      end
      default: ;
    endcase
  endtask

  // Entered just after a rising edge; leaves just after a rising edge.
  task automatic run_steps(input int n, input logic [5:0] opc, input logic [5:0] fnc, input int id);
    int k = 0;
    while (steps.size() > 0 && k < n) begin
      step_t s;
      s = steps.pop_front();
      OpCode = opc; Funct = fnc; MemReady = s.ready;
      @(negedge clk);
      check_eq($sformatf("i%0d_c%0d", id, k), {7'd0, act & s.m}, {7'd0, s.e & s.m});
      @(posedge clk);
      #1;
      k++;
    end
    steps.delete();
  endtask

  task automatic do_instr(input logic [5:0] opc, input logic [5:0] fnc, input int ifs,
                          input int ms, input int id);
    gen_instr(opc, fnc, ifs, ms);
    run_steps(1000, opc, fnc, id);
  endtask

  logic [5:0] op_tab [18] = '{6'h00, 6'h00, 6'h00, 6'h1c, 6'h23, 6'h2b, 6'h04, 6'h05, 6'h02,
                              6'h03, 6'h08, 6'h09, 6'h0a, 6'h0b, 6'h0c, 6'h0d, 6'h0f, 6'h3f};
  logic [5:0] fn_tab [10] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2a, 6'h00, 6'h02, 6'h03, 6'h08, 6'h09};

  initial begin
    logic [5:0] opc, fnc;
    int pick;
    reset = 1'b1; MemReady = 1'b0; OpCode = 6'h00; Funct = 6'h00;
    #3;
    check_eq("reset_outputs", {7'd0, act}, 32'd0);
    MemReady = 1'b1;
    #1;
    check_eq("reset_outputs_ready", {7'd0, act}, 32'd0);
    MemReady = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;

    do_instr(6'h00, 6'h20, 0, 0, 1);   // add
    do_instr(6'h0b, 6'h00, 0, 0, 2);   // sltiu
    do_instr(6'h0c, 6'h00, 1, 0, 3);   // andi
    do_instr(6'h23, 6'h00, 0, 3, 4);   // lw, three wait cycles
    do_instr(6'h05, 6'h00, 0, 0, 5);   // bne
    do_instr(6'h3f, 6'h00, 0, 0, 6);   // illegal
    do_instr(6'h04, 6'h00, 0, 0, 7);   // beq
    do_instr(6'h03, 6'h00, 0, 0, 8);   // jal
    do_instr(6'h00, 6'h09, 0, 0, 9);   // jalr
    do_instr(6'h00, 6'h08, 0, 0, 10);  // jr
    do_instr(6'h1c, 6'h02, 0, 0, 11);  // mul
    do_instr(6'h00, 6'h02, 0, 0, 12);  // srl
    do_instr(6'h0f, 6'h00, 0, 0, 13);  // lui
    do_instr(6'h2b, 6'h00, 2, 1, 14);  // sw
    do_instr(6'h1c, 6'h05, 0, 0, 15);  // unsupported SPECIAL2 funct

    for (int i = 0; i < 40; i++) begin
      pick = $urandom_range(0, 19);
      opc = (pick < 18) ? op_tab[pick] : 6'($urandom_range(0, 63));
      if (opc == 6'h00) fnc = ($urandom_range(0, 3) == 0) ? 6'($urandom_range(0, 63))
                                                        : fn_tab[$urandom_range(0, 9)];
      else if (opc == 6'h1c) fnc = ($urandom_range(0, 3) == 0) ? 6'($urandom_range(0, 63)) : 6'h02;
      else fnc = 6'($urandom_range(0, 63));
      do_instr(opc, fnc, $urandom_range(0, 2), $urandom_range(0, 3), 100 + i);
    end

    // Reset while sw is waiting in the memory-write state.
    gen_instr(6'h2b, 6'h00, 0, 5);
    run_steps(5, 6'h2b, 6'h00, 200);
    MemReady = 1'b0;
    #1;
    check_eq("mwr_before_reset", 32'(MemWrite), 32'd1);
    reset = 1'b1;
    #1;
    check_eq("rst_mwr_memwrite", 32'(MemWrite), 32'd0);
    check_eq("rst_mwr_all", {7'd0, act}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check_eq("post_rst_memread", 32'(MemRead), 32'd1);
    check_eq("post_rst_regwrite", 32'(RegWrite), 32'd0);
    @(posedge clk);
    #1;
    do_instr(6'h00, 6'h25, 0, 0, 201);
    do_instr(6'h23, 6'h00, 0, 0, 202);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
